stack_ctl: RTL and testbench

- Control stage directly upstream of the shift-register data stack (`stack2`); owns the top-of-stack register T.
- Translates host stack commands (valid/ready handshake) into the stack's `we`/`delta`/`wd` controls.
- Tracks depth and raises sticky overflow/underflow flags.
- Used by the Forth core's debug/host port and as a standalone stack engine; the parent instantiates `stack2` beside it and wires the `stk_*` ports.

---
 rtl/stack_pkg.sv | 35 +++
 rtl/stack_ctl.sv | 166 ++++++++++++++++
 tb/tb_stack_ctl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared encodings for the stack control stage: host op codes, stack delta codes, ROT FSM states.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_DUP  = 3'd3,
    OP_SWAP = 3'd4,
    OP_OVER = 3'd5,
    OP_NIP  = 3'd6,
    OP_ROT  = 3'd7
  } op_t;

  localparam logic [1:0] DLT_HOLD = 2'b00;
  localparam logic [1:0] DLT_PUSH = 2'b01;
  localparam logic [1:0] DLT_POP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT1 = 2'd1,
    ST_ROT2 = 2'd2
  } state_t;

  // Elements (including T) an op must find present to avoid underflow.
  function automatic logic [1:0] req_depth(op_t op);
    case (op)
      OP_POP, OP_DUP:          req_depth = 2'd1;
      OP_SWAP, OP_OVER, OP_NIP: req_depth = 2'd2;
      OP_ROT:                  req_depth = 2'd3;
      default:                 req_depth = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_ctl.sv
// Host-command front end for a shift-register data stack; owns T, tracks depth and sticky errors.
// Single-cycle ops respond 1 cycle after accept, ROT after 3; cmd_ready drops only while ROT runs.
module stack_ctl
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetq,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [WIDTH-1:0]              cmd_data,
  output logic                          rsp_valid,
  output logic [WIDTH-1:0]              rsp_data,
  output logic [WIDTH-1:0]              tos,
  output logic [$clog2(DEPTH+2)-1:0]    depth,
  output logic                          err_ovf,
  output logic                          err_unf,
  input  logic                          err_clr,
  output logic                          stk_we,
  output logic [1:0]                    stk_delta,
  output logic [WIDTH-1:0]              stk_wd,
  input  logic [WIDTH-1:0]              stk_rd
);

  localparam int DW = $clog2(DEPTH+2);
  localparam logic [DW-1:0] MAX_DEPTH = DW'(DEPTH+1);

  state_t           r_state;
  logic [WIDTH-1:0] r_tos;
  logic [DW-1:0]    r_depth;
  logic             r_ovf;
  logic             r_unf;
  logic             r_rsp_vld;
  logic [WIDTH-1:0] r_rsp_dat;
  logic [WIDTH-1:0] r_tmp_b;
  logic [WIDTH-1:0] r_tmp_c;

  op_t              w_op;
  logic             w_acc;
  logic             w_we;
  logic [1:0]       w_delta;
  logic [WIDTH-1:0] w_wd;
  logic             w_inc;
  logic             w_dec;

  assign w_op      = op_t'(cmd_op);
  assign cmd_ready = (r_state == ST_IDLE);
  assign w_acc     = resetq && cmd_valid && cmd_ready;

  always_comb begin
    w_we    = 1'b0;
    w_delta = DLT_HOLD;
    w_wd    = r_tos;
    w_inc   = 1'b0;
    w_dec   = 1'b0;
    if (resetq) begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            case (w_op)
              OP_PUSH, OP_DUP, OP_OVER: begin
                w_we    = 1'b1;
                w_delta = DLT_PUSH;
                w_inc   = 1'b1;
              end
              OP_POP, OP_NIP: begin
                w_delta = DLT_POP;
                w_dec   = 1'b1;
              end
              OP_SWAP: w_we = 1'b1;
              // ROT lifts b out of N; it is written back in ROT1.
              OP_ROT:  w_delta = DLT_POP;
              default: ;
            endcase
          end
        end
        ST_ROT1: begin
          w_we = 1'b1;
          w_wd = r_tmp_b;
        end
        ST_ROT2: begin
          w_we    = 1'b1;
          w_delta = DLT_PUSH;
          w_wd    = r_tmp_c;
        end
        default: ;
      endcase
    end
  end

  assign stk_we    = w_we;
  assign stk_delta = w_delta;
  assign stk_wd    = w_wd;

  always_ff @(posedge clk) begin
    if (!resetq) begin
      r_state   <= ST_IDLE;
      r_tos     <= '0;
      r_depth   <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= '0;
      r_tmp_b   <= '0;
      r_tmp_c   <= '0;
    end else begin
      r_rsp_vld <= 1'b0;
      if (err_clr) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            if (r_depth < DW'(req_depth(w_op))) r_unf <= 1'b1;
            if (w_inc) begin
              if (r_depth == MAX_DEPTH) r_ovf <= 1'b1;
              else                      r_depth <= r_depth + 1'b1;
            end
            if (w_dec && r_depth != '0) r_depth <= r_depth - 1'b1;
            r_rsp_vld <= (w_op != OP_ROT);
            r_rsp_dat <= r_tos;
            case (w_op)
              OP_PUSH: begin
                r_tos     <= cmd_data;
                r_rsp_dat <= cmd_data;
              end
              OP_POP: r_tos <= stk_rd;
              OP_SWAP, OP_OVER: begin
                r_tos     <= stk_rd;
                r_rsp_dat <= stk_rd;
              end
              OP_ROT: begin
                r_tmp_b <= stk_rd;
                r_tmp_c <= r_tos;
                r_state <= ST_ROT1;
              end
              default: ;
            endcase
          end
        end
        ST_ROT1: begin
          r_tos   <= stk_rd;
          r_state <= ST_ROT2;
        end
        ST_ROT2: begin
          r_rsp_vld <= 1'b1;
          r_rsp_dat <= r_tos;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_vld;
  assign rsp_data  = r_rsp_dat;
  assign tos       = r_tos;
  assign depth     = r_depth;
  assign err_ovf   = r_ovf;
  assign err_unf   = r_unf;

endmodule

// File: tb/tb_stack_ctl.sv
// Bench for stack_ctl with a behavioural shift-register stack attached to the stk_* ports.
module tb_stack_ctl;
  import stack_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              resetq;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [WIDTH-1:0]  cmd_data;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_data;
  logic [WIDTH-1:0]  tos;
  logic [4:0]        depth;
  logic              err_ovf;
  logic              err_unf;
  logic              err_clr;
  logic              stk_we;
  logic [1:0]        stk_delta;
  logic [WIDTH-1:0]  stk_wd;
  logic [WIDTH-1:0]  stk_rd;

  logic [WIDTH-1:0]  m_stk [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stack_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetq(resetq),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .tos(tos), .depth(depth),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_clr(err_clr),
    .stk_we(stk_we), .stk_delta(stk_delta), .stk_wd(stk_wd), .stk_rd(stk_rd)
  );

  // Reference stack: push shifts down and writes wd, pop shifts up, hold+we overwrites N.
  assign stk_rd = m_stk[0];
  always @(posedge clk) begin
    if (stk_delta == 2'b01) begin
      for (int i = DEPTH-1; i > 0; i--) m_stk[i] <= m_stk[i-1];
      m_stk[0] <= stk_wd;
    end else if (stk_delta == 2'b11) begin
      for (int i = 0; i < DEPTH-1; i++) m_stk[i] <= m_stk[i+1];
    end else if (stk_we) begin
      m_stk[0] <= stk_wd;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [WIDTH-1:0] data, input logic clr);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    err_clr   = clr;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    err_clr   = 1'b0;
  endtask

  task automatic do_reset();
    resetq = 1'b0;
    @(posedge clk); #1;
    resetq = 1'b1;
  endtask

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] rsp;
    logic [WIDTH-1:0] tos;
    logic [4:0]       dep;
  } vec_t;

  vec_t tbl [13];

  initial begin
    for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;

    tbl[0]  = '{OP_PUSH, 16'h0011, 16'h0011, 16'h0011, 5'd1};
    tbl[1]  = '{OP_PUSH, 16'h0022, 16'h0022, 16'h0022, 5'd2};
    tbl[2]  = '{OP_PUSH, 16'h0033, 16'h0033, 16'h0033, 5'd3};
    tbl[3]  = '{OP_POP,  16'h0000, 16'h0033, 16'h0022, 5'd2};
    tbl[4]  = '{OP_POP,  16'h0000, 16'h0022, 16'h0011, 5'd1};
    tbl[5]  = '{OP_POP,  16'h0000, 16'h0011, 16'h0000, 5'd0};
    tbl[6]  = '{OP_PUSH, 16'h0001, 16'h0001, 16'h0001, 5'd1};
    tbl[7]  = '{OP_PUSH, 16'h0002, 16'h0002, 16'h0002, 5'd2};
    tbl[8]  = '{OP_SWAP, 16'h0000, 16'h0001, 16'h0001, 5'd2};
    tbl[9]  = '{OP_POP,  16'h0000, 16'h0001, 16'h0002, 5'd1};
    tbl[10] = '{OP_DUP,  16'h0000, 16'h0002, 16'h0002, 5'd2};
    tbl[11] = '{OP_NIP,  16'h0000, 16'h0002, 16'h0002, 5'd1};
    tbl[12] = '{OP_POP,  16'h0000, 16'h0002, 16'h0000, 5'd0};

    resetq    = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_PUSH;
    cmd_data  = 16'h1234;
    err_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stk_we",    {31'b0, stk_we}, 32'd0);
    chk("rst_stk_delta", {30'b0, stk_delta}, 32'd0);
    chk("rst_tos",       {16'b0, tos}, 32'd0);
    chk("rst_depth",     {27'b0, depth}, 32'd0);
    chk("rst_flags",     {30'b0, err_ovf, err_unf}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    cmd_valid = 1'b0;
    resetq    = 1'b1;
    chk("rst_ready",     {31'b0, cmd_ready}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      do_cmd(tbl[i].op, tbl[i].data, 1'b0);
      chk($sformatf("vec%0d_rsp_valid", i), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("vec%0d_rsp_data", i),  {16'b0, rsp_data}, {16'b0, tbl[i].rsp});
      chk($sformatf("vec%0d_tos", i),       {16'b0, tos}, {16'b0, tbl[i].tos});
      chk($sformatf("vec%0d_depth", i),     {27'b0, depth}, {27'b0, tbl[i].dep});
      chk($sformatf("vec%0d_flags", i),     {30'b0, err_ovf, err_unf}, 32'd0);
    end
    @(posedge clk); #1;
    chk("idle_rsp_pulse", {31'b0, rsp_valid}, 32'd0);

    // ROT: a b c -- b c a
    do_cmd(OP_PUSH, 16'h000A, 1'b0);
    do_cmd(OP_PUSH, 16'h000B, 1'b0);
    do_cmd(OP_PUSH, 16'h000C, 1'b0);
    do_cmd(OP_ROT, 16'h0000, 1'b0);
    chk("rot_c1_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rot_c1_rsp",   {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rot_c2_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rot_c2_rsp",   {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rot_c3_rsp",   {31'b0, rsp_valid}, 32'd1);
    chk("rot_c3_data",  {16'b0, rsp_data}, 32'h000A);
    chk("rot_c3_tos",   {16'b0, tos}, 32'h000A);
    chk("rot_c3_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rot_depth",    {27'b0, depth}, 32'd3);
    chk("rot_unf",      {31'b0, err_unf}, 32'd0);
    do_cmd(OP_POP, 16'h0000, 1'b0);
    chk("rot_pop1", {16'b0, rsp_data}, 32'h000A);
    do_cmd(OP_POP, 16'h0000, 1'b0);
    chk("rot_pop2", {16'b0, rsp_data}, 32'h000C);
    do_cmd(OP_POP, 16'h0000, 1'b0);
    chk("rot_pop3", {16'b0, rsp_data}, 32'h000B);
    chk("rot_pop_depth", {27'b0, depth}, 32'd0);

    // Overflow at DEPTH+1 elements
    for (int i = 0; i < DEPTH+1; i++) do_cmd(OP_PUSH, 16'(i + 1), 1'b0);
    chk("full_depth", {27'b0, depth}, 32'd17);
    chk("full_ovf",   {31'b0, err_ovf}, 32'd0);
    do_cmd(OP_PUSH, 16'h00FF, 1'b0);
    chk("ovf_set",    {31'b0, err_ovf}, 32'd1);
    chk("ovf_depth",  {27'b0, depth}, 32'd17);
    chk("ovf_tos",    {16'b0, tos}, 32'h00FF);
    do_cmd(OP_NOP, 16'h0000, 1'b1);
    chk("ovf_clr",    {31'b0, err_ovf}, 32'd0);
    chk("ovf_clr_depth", {27'b0, depth}, 32'd17);

    // Underflow and error-wins-over-clear
    do_reset();
    do_cmd(OP_POP, 16'h0000, 1'b0);
    chk("unf_set",    {31'b0, err_unf}, 32'd1);
    chk("unf_depth0", {27'b0, depth}, 32'd0);
    do_cmd(OP_PUSH, 16'h0005, 1'b0);
    do_cmd(OP_OVER, 16'h0000, 1'b0);
    chk("unf_sticky", {31'b0, err_unf}, 32'd1);
    chk("unf_over_depth", {27'b0, depth}, 32'd2);
    do_cmd(OP_NIP, 16'h0000, 1'b1);
    chk("unf_clr",    {31'b0, err_unf}, 32'd0);
    chk("unf_nip_depth", {27'b0, depth}, 32'd1);
    do_cmd(OP_POP, 16'h0000, 1'b0);
    do_cmd(OP_POP, 16'h0000, 1'b1);
    chk("err_wins",   {31'b0, err_unf}, 32'd1);
    chk("err_wins_depth", {27'b0, depth}, 32'd0);

    // Reset while ROT is in flight
    do_reset();
    do_cmd(OP_PUSH, 16'h0001, 1'b0);
    do_cmd(OP_PUSH, 16'h0002, 1'b0);
    do_cmd(OP_PUSH, 16'h0003, 1'b0);
    do_cmd(OP_ROT, 16'h0000, 1'b0);
    chk("mid_rot_busy", {31'b0, cmd_ready}, 32'd0);
    resetq = 1'b0;
    #1;
    chk("mid_rot_stk_we", {31'b0, stk_we}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rot_depth", {27'b0, depth}, 32'd0);
    chk("mid_rot_tos",   {16'b0, tos}, 32'd0);
    chk("mid_rot_rsp",   {31'b0, rsp_valid}, 32'd0);
    resetq = 1'b1;
    chk("mid_rot_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    chk("mid_rot_no_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rot_ready2", {31'b0, cmd_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
